button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: cycles an input must hold a new value before it is accepted, >=2.
REQ-003 Parameter EDGE_MODE, default 0: pulse trigger; 0 = rising, 1 = falling, 2 = both edges.
REQ-004 Parameter REPEAT_DELAY, default 50000: cycles from press pulse to first repeat pulse; used only with BUTTON_REPEAT_EN.
REQ-005 Parameter REPEAT_PERIOD, default 10000: cycles between repeat pulses; used only with BUTTON_REPEAT_EN.
REQ-006 clk  input  1  single system clock, all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 button_in  input  N_CH  raw asynchronous button levels, one bit per channel.
REQ-009 level_out  output  N_CH  debounced, synchronised button level per channel.
REQ-010 pulse_out  output  N_CH  single-cycle event pulse per channel.

Function
REQ-011 Each button_in bit shall pass through a 2-flop synchroniser before any other logic.
REQ-012 Per channel, a counter of width $clog2(DEBOUNCE_CYCLES) bits shall increment each cycle the synchronised value differs from level_out, and clear whenever they are equal.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, level_out shall take the synchronised value on that edge and the counter shall clear.
REQ-014 A clean input step shall appear on level_out exactly DEBOUNCE_CYCLES+2 rising edges after the step is first sampled.
REQ-015 Any glitch or bounce shorter than DEBOUNCE_CYCLES synchronised cycles shall leave level_out and pulse_out unchanged and restart the count.
REQ-016 pulse_out[i] shall be high for exactly one cycle, the cycle level_out[i] changes in a direction selected by EDGE_MODE.
REQ-017 A held button (stable level) shall produce no further pulses unless BUTTON_REPEAT_EN is defined.
REQ-018 Channels shall be fully independent; simultaneous events on several channels shall each produce their own pulse in the same cycle.
REQ-019 Counters shall never wrap; they saturate at acceptance and clear.

Reset
REQ-020 On rst low, synchronisers, counters, repeat timers, level_out and pulse_out shall clear to 0 immediately, regardless of clk.
REQ-021 Reset asserted mid-debounce or mid-repeat shall abort it; after release, a held-high input is treated as a new press (rising pulse after DEBOUNCE_CYCLES+2 edges).

Configuration
REQ-022 Macro BUTTON_REPEAT_EN defined: while level_out[i] is 1, a repeat timer shall emit a pulse REPEAT_DELAY cycles after the press edge, then every REPEAT_PERIOD cycles, in any EDGE_MODE.
REQ-023 With BUTTON_REPEAT_EN, release (level_out[i] to 0) shall stop and clear the repeat timer on that edge; a repeat pulse never coincides with a press/release pulse.
REQ-024 Macro undefined: no repeat timer logic shall be synthesised and REPEAT_DELAY/REPEAT_PERIOD are ignored.

Structure
REQ-025 A shared package button_pkg shall hold the EDGE_MODE constants (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2) and the default timing constants.
REQ-026 Per-channel logic shall live in sub-module button_channel, instantiated N_CH times via generate.

Verification (N_CH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 Clean press on ch0, EDGE_MODE=0 -> level_out[0] rises 6 edges later, pulse_out=4'b0001 for one cycle.
REQ-028 ch1 toggles 1,0,1,0 every 2 cycles then holds 1 -> no pulse during bounce, single pulse 6 edges after final settle.
REQ-029 EDGE_MODE=2, press then release ch2 -> two one-cycle pulses, one per edge; EDGE_MODE=1 -> release pulse only.
REQ-030 All 4 channels pressed same cycle -> pulse_out=4'b1111 for one cycle.
REQ-031 rst low 2 cycles after level_out[3] rises, input held high -> outputs 0 instantly; new pulse 6 edges after rst release.
REQ-032 BUTTON_REPEAT_EN, ch0 held 60 cycles -> pulses at press, +20, +28, +36, ...; release stops them.

Source files
------------

// File: rtl/button_pkg.sv
// Shared edge-mode encodings, default timing constants and the edge-selection helper
// for the button conditioner.
package button_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_REPEAT_DELAY    = 50000;
  localparam int DEF_REPEAT_PERIOD   = 10000;

  // True when a level change towards 'rising' should raise a pulse under 'mode'.
  function automatic logic edge_selected(input int mode, input logic rising);
    case (mode)
      EDGE_RISE: return rising;
      EDGE_FALL: return !rising;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, saturating debounce counter, edge pulse and,
// when BUTTON_REPEAT_EN is defined, a hold-to-repeat timer.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = EDGE_RISE
`ifdef BUTTON_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic level_out,
  output logic pulse_out
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;
  logic             edge_hit;

  // Stage p0/p1: synchroniser on the raw asynchronous level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button_in;
      sync_p1 <= sync_p0;
    end
  end

  assign differ   = sync_p1 ^ level_out;
  assign accept   = differ && (cnt == CNT_LAST);
  assign edge_hit = accept && edge_selected(EDGE_MODE, sync_p1);

  // Debounce stage: any return to the accepted level restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      level_out <= 1'b0;
    end else if (!differ || accept) begin
      cnt <= '0;
      if (accept) level_out <= sync_p1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] rep_cnt;
  logic             rep_hit;

  // An accepting edge (press or release) always wins over a repeat on the same cycle.
  assign rep_hit = level_out && !accept && (rep_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (accept) begin
      rep_cnt <= sync_p1 ? REP_W'(REPEAT_DELAY - 1) : '0;
    end else if (level_out) begin
      rep_cnt <= rep_hit ? REP_W'(REPEAT_PERIOD - 1) : rep_cnt - REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_out <= 1'b0;
    else      pulse_out <= edge_hit || rep_hit;
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_out <= 1'b0;
    else      pulse_out <= edge_hit;
  end
`endif

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent debounced button channels with edge pulses.
// Define BUTTON_REPEAT_EN to add the hold-to-repeat pulse timer per channel.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] pulse_out
);

  // Out-of-range configurations elaborate this marker scope so they show up in the hierarchy.
  if (N_CH < 1 || N_CH > 32 || DEBOUNCE_CYCLES < 2 || EDGE_MODE < EDGE_RISE ||
      EDGE_MODE > EDGE_BOTH || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_config
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE)
`ifdef BUTTON_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .button_in(button_in[i]),
      .level_out(level_out[i]),
      .pulse_out(pulse_out[i])
    );
  end

endmodule
